// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decode control bundles through ID/EX, EX/MEM and MEM/WB,
// inserts load-use bubbles, squashes wrong-path entries on a taken branch and
// counts retired instructions.
module ctrl_pipeline #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_exCtrl,
  input  logic [2:0]       id_memCtrl,
  input  logic [1:0]       id_wbCtrl,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             branch_taken,
  output logic             stall_out,
  output logic             ex_valid,
  output logic [2:0]       ex_exCtrl,
  output logic [2:0]       ex_memCtrl,
  output logic [1:0]       ex_wbCtrl,
  output logic [RA_W-1:0]  ex_rd,
  output logic             mem_valid,
  output logic [2:0]       mem_memCtrl,
  output logic [1:0]       mem_wbCtrl,
  output logic [RA_W-1:0]  mem_rd,
  output logic             wb_valid,
  output logic [1:0]       wb_wbCtrl,
  output logic [RA_W-1:0]  wb_rd,
  output logic [CNT_W-1:0] retired_cnt
);

  // Bit positions inside the memCtrl bundle {dataMemRead, dataMemWrite, Branch}
  localparam int unsigned MEM_READ_BIT = 2;
  localparam int unsigned BRANCH_BIT   = 0;

  logic taken;
  logic rdMatch;
  logic idLoad;

  // Branch resolution in MEM, load-use detection against the EX entry
  always_comb begin
    taken     = branch_taken & mem_valid & mem_memCtrl[BRANCH_BIT];
    rdMatch   = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    stall_out = ~taken & ex_valid & ex_memCtrl[MEM_READ_BIT] &
                (ex_rd != RA_W'(0)) & id_valid & rdMatch;
    idLoad    = id_valid & ~stall_out & ~taken;
  end

  // All pipeline registers and the retirement counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_exCtrl   <= 3'b000;
      ex_memCtrl  <= 3'b000;
      ex_wbCtrl   <= 2'b00;
      ex_rd       <= RA_W'(0);
      mem_valid   <= 1'b0;
      mem_memCtrl <= 3'b000;
      mem_wbCtrl  <= 2'b00;
      mem_rd      <= RA_W'(0);
      wb_valid    <= 1'b0;
      wb_wbCtrl   <= 2'b00;
      wb_rd       <= RA_W'(0);
      retired_cnt <= CNT_W'(0);
    end else begin
      // ID/EX: real decode entry, or a fully zeroed bubble
      if (idLoad) begin
        ex_valid   <= 1'b1;
        ex_exCtrl  <= id_exCtrl;
        ex_memCtrl <= id_memCtrl;
        ex_wbCtrl  <= id_wbCtrl;
        ex_rd      <= id_rd;
      end else begin
        ex_valid   <= 1'b0;
        ex_exCtrl  <= 3'b000;
        ex_memCtrl <= 3'b000;
        ex_wbCtrl  <= 2'b00;
        ex_rd      <= RA_W'(0);
      end

      // EX/MEM: wrong-path entry is squashed when the branch in MEM is taken
      if (taken) begin
        mem_valid   <= 1'b0;
        mem_memCtrl <= 3'b000;
        mem_wbCtrl  <= 2'b00;
        mem_rd      <= RA_W'(0);
      end else begin
        mem_valid   <= ex_valid;
        mem_memCtrl <= ex_memCtrl;
        mem_wbCtrl  <= ex_wbCtrl;
        mem_rd      <= ex_rd;
      end

      // MEM/WB always advances; the branch itself retires normally
      wb_valid  <= mem_valid;
      wb_wbCtrl <= mem_wbCtrl;
      wb_rd     <= mem_rd;

      if (wb_valid) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios plus randomized
// traffic compared against a stage-entry reference model.
module tb_ctrl_pipeline;

  localparam int unsigned RA_W  = 5;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic            v;
    logic [2:0]      ec;
    logic [2:0]      mc;
    logic [1:0]      wc;
    logic [RA_W-1:0] rd;
  } ent_t;

  localparam ent_t BUB = '0;

  logic             clk;
  logic             rst;
  logic             idValid;
  logic [2:0]       idEx;
  logic [2:0]       idMem;
  logic [1:0]       idWb;
  logic [RA_W-1:0]  idRd;
  logic [RA_W-1:0]  idRs1;
  logic [RA_W-1:0]  idRs2;
  logic             brTaken;

  logic             stall_out;
  logic             ex_valid;
  logic [2:0]       ex_exCtrl;
  logic [2:0]       ex_memCtrl;
  logic [1:0]       ex_wbCtrl;
  logic [RA_W-1:0]  ex_rd;
  logic             mem_valid;
  logic [2:0]       mem_memCtrl;
  logic [1:0]       mem_wbCtrl;
  logic [RA_W-1:0]  mem_rd;
  logic             wb_valid;
  logic [1:0]       wb_wbCtrl;
  logic [RA_W-1:0]  wb_rd;
  logic [CNT_W-1:0] retired_cnt;

  int vecs = 0;
  int miss = 0;

  // Reference model: one entry per pipeline stage plus a retirement count
  ent_t mEx, mMem, mWb;
  int   mCnt;

  ctrl_pipeline #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst),
    .id_valid(idValid), .id_exCtrl(idEx), .id_memCtrl(idMem), .id_wbCtrl(idWb),
    .id_rd(idRd), .id_rs1(idRs1), .id_rs2(idRs2), .branch_taken(brTaken),
    .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_exCtrl(ex_exCtrl), .ex_memCtrl(ex_memCtrl),
    .ex_wbCtrl(ex_wbCtrl), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_memCtrl(mem_memCtrl), .mem_wbCtrl(mem_wbCtrl),
    .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_wbCtrl(wb_wbCtrl), .wb_rd(wb_rd),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic modelTaken();
    return brTaken && mMem.v && mMem.mc[0];
  endfunction

  function automatic logic modelStall();
    return !modelTaken() && mEx.v && mEx.mc[2] && (mEx.rd != 0) && idValid &&
           ((mEx.rd == idRs1) || (mEx.rd == idRs2));
  endfunction

  task automatic drive(input logic v, input logic [2:0] ex, input logic [2:0] mem,
                       input logic [1:0] wb, input int rd, input int rs1, input int rs2);
    idValid = v;
    idEx    = ex;
    idMem   = mem;
    idWb    = wb;
    idRd    = RA_W'(rd);
    idRs1   = RA_W'(rs1);
    idRs2   = RA_W'(rs2);
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 3'b000, 2'b00, 0, 0, 0);
  endtask

  // One clock edge for DUT and model; returns #1 after the edge
  task automatic tick();
    logic tk, st;
    tk = modelTaken();
    st = modelStall();
    @(posedge clk);
    if (rst) begin
      mEx = BUB; mMem = BUB; mWb = BUB; mCnt = 0;
    end else begin
      if (mWb.v) mCnt = (mCnt + 1) % (1 << CNT_W);
      mWb  = mMem;
      mMem = tk ? BUB : mEx;
      if (idValid && !st && !tk) mEx = '{1'b1, idEx, idMem, idWb, idRd};
      else                       mEx = BUB;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; brTaken = 1'b0;
    drive(1'b1, 3'b111, 3'b111, 2'b11, 7, 7, 7);
    tick();
    vecs++;
    if ({ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd, mem_valid, mem_memCtrl,
         mem_wbCtrl, mem_rd, wb_valid, wb_wbCtrl, wb_rd, retired_cnt} !== '0) begin
      miss++;
      $display("FAIL reset_outputs: ex=%b mem=%b wb=%b cnt=%0d, want all 0",
               {ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd},
               {mem_valid, mem_memCtrl, mem_wbCtrl, mem_rd},
               {wb_valid, wb_wbCtrl, wb_rd}, retired_cnt);
    end
    vecs++;
    if (stall_out !== 1'b0) begin
      miss++; $display("FAIL reset_stall: got %b want 0", stall_out);
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_advance();
    drive(1'b1, 3'b100, 3'b000, 2'b01, 5, 1, 2);
    tick();
    idle();
    vecs++;
    if ({ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd} !== {1'b1, 3'b100, 3'b000, 2'b01, 5'd5}) begin
      miss++; $display("FAIL advance_ex: got %b want 1_100_000_01_00101",
                       {ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd});
    end
    tick();
    vecs++;
    if ({ex_valid, mem_valid, mem_memCtrl, mem_wbCtrl, mem_rd} !== {1'b0, 1'b1, 3'b000, 2'b01, 5'd5}) begin
      miss++; $display("FAIL advance_mem: got %b want 0_1_000_01_00101",
                       {ex_valid, mem_valid, mem_memCtrl, mem_wbCtrl, mem_rd});
    end
    tick();
    vecs++;
    if ({wb_valid, wb_wbCtrl, wb_rd, retired_cnt} !== {1'b1, 2'b01, 5'd5, 4'd0}) begin
      miss++; $display("FAIL advance_wb: got v=%b wc=%b rd=%0d cnt=%0d want 1 01 5 0",
                       wb_valid, wb_wbCtrl, wb_rd, retired_cnt);
    end
    tick();
    vecs++;
    if (retired_cnt !== 4'd1 || wb_valid !== 1'b0) begin
      miss++; $display("FAIL advance_retire: cnt=%0d wbv=%b want 1 0", retired_cnt, wb_valid);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 3'b100, 3'b100, 2'b11, 7, 1, 2);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 9, 7, 0);
    #1;
    vecs++;
    if (stall_out !== 1'b1) begin
      miss++; $display("FAIL loaduse_stall: got %b want 1", stall_out);
    end
    tick();
    vecs++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || mem_rd !== 5'd7 || mem_valid !== 1'b1) begin
      miss++; $display("FAIL loaduse_bubble: exv=%b exrd=%0d memv=%b memrd=%0d want 0 0 1 7",
                       ex_valid, ex_rd, mem_valid, mem_rd);
    end
    vecs++;
    if (stall_out !== 1'b0) begin
      miss++; $display("FAIL loaduse_release: got %b want 0", stall_out);
    end
    tick();
    vecs++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin
      miss++; $display("FAIL loaduse_dep_in_ex: v=%b rd=%0d want 1 9", ex_valid, ex_rd);
    end
    drive(1'b1, 3'b100, 3'b100, 2'b11, 7, 1, 2);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 9, 8, 3);
    #1;
    vecs++;
    if (stall_out !== 1'b0) begin
      miss++; $display("FAIL loaduse_nodep: got %b want 0", stall_out);
    end
    tick();
    vecs++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin
      miss++; $display("FAIL loaduse_nodep_ex: v=%b rd=%0d want 1 9", ex_valid, ex_rd);
    end
    idle();
  endtask

  task automatic test_load_rd0();
    drive(1'b1, 3'b100, 3'b100, 2'b10, 0, 4, 5);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 6, 0, 0);
    #1;
    vecs++;
    if (stall_out !== 1'b0) begin
      miss++; $display("FAIL load_rd0_stall: got %b want 0", stall_out);
    end
    tick();
    idle();
  endtask

  task automatic test_branch_flush();
    drive(1'b1, 3'b000, 3'b001, 2'b00, 3, 1, 2);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 10, 0, 0);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 11, 0, 0);
    brTaken = 1'b1;
    #1;
    vecs++;
    if (stall_out !== 1'b0) begin
      miss++; $display("FAIL flush_stall: got %b want 0", stall_out);
    end
    tick();
    brTaken = 1'b0;
    vecs++;
    if ({ex_valid, mem_valid, wb_valid, wb_rd} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
      miss++; $display("FAIL flush_taken: exv=%b memv=%b wbv=%b wbrd=%0d want 0 0 1 3",
                       ex_valid, mem_valid, wb_valid, wb_rd);
    end
    drive(1'b1, 3'b000, 3'b000, 2'b01, 12, 0, 0);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 13, 0, 0);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 14, 0, 0);
    brTaken = 1'b1;
    tick();
    brTaken = 1'b0;
    vecs++;
    if ({ex_valid, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd} !==
        {1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd12}) begin
      miss++; $display("FAIL flush_nonbranch: ex=%b/%0d mem=%b/%0d wb=%b/%0d want 1/14 1/13 1/12",
                       ex_valid, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd);
    end
    idle();
  endtask

  task automatic test_stall_and_flush();
    drive(1'b1, 3'b000, 3'b001, 2'b00, 4, 0, 0);
    tick();
    drive(1'b1, 3'b100, 3'b100, 2'b11, 7, 0, 0);
    tick();
    drive(1'b1, 3'b000, 3'b000, 2'b01, 9, 7, 0);
    brTaken = 1'b0;
    #1;
    vecs++;
    if (stall_out !== 1'b1) begin
      miss++; $display("FAIL both_stall_alone: got %b want 1", stall_out);
    end
    brTaken = 1'b1;
    #1;
    vecs++;
    if (stall_out !== 1'b0) begin
      miss++; $display("FAIL both_stall_forced: got %b want 0", stall_out);
    end
    tick();
    brTaken = 1'b0;
    vecs++;
    if ({ex_valid, mem_valid, wb_valid, wb_rd} !== {1'b0, 1'b0, 1'b1, 5'd4}) begin
      miss++; $display("FAIL both_flush: exv=%b memv=%b wbv=%b wbrd=%0d want 0 0 1 4",
                       ex_valid, mem_valid, wb_valid, wb_rd);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 3'b011, 3'b001, 2'b11, 6, 0, 0);
    tick();
    drive(1'b1, 3'b101, 3'b100, 2'b10, 8, 6, 0);
    tick();
    tick();
    rst = 1'b1;
    brTaken = 1'b1;
    tick();
    vecs++;
    if ({ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd, mem_valid, mem_memCtrl,
         mem_wbCtrl, mem_rd, wb_valid, wb_wbCtrl, wb_rd, retired_cnt, stall_out} !== '0) begin
      miss++; $display("FAIL midreset: ex=%b mem=%b wb=%b cnt=%0d stall=%b want all 0",
                       {ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd},
                       {mem_valid, mem_memCtrl, mem_wbCtrl, mem_rd},
                       {wb_valid, wb_wbCtrl, wb_rd}, retired_cnt, stall_out);
    end
    rst = 1'b0;
    brTaken = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 3'(i), 3'b000, 2'(i), i + 1, 0, 0);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
    vecs++;
    if (retired_cnt !== 4'd15) begin
      miss++; $display("FAIL wrap_15: got %0d want 15", retired_cnt);
    end
    drive(1'b1, 3'b000, 3'b000, 2'b01, 2, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    vecs++;
    if (retired_cnt !== 4'd0) begin
      miss++; $display("FAIL wrap_0: got %0d want 0", retired_cnt);
    end
  endtask

  task automatic test_random();
    logic st;
    for (int n = 0; n < 400; n++) begin
      brTaken = ($urandom_range(0, 3) == 0);
      vecs++;
      st = modelStall();
      #1;
      if (stall_out !== st) begin
        miss++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall_out, st);
      end
      tick();
      vecs++;
      if ({ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd} !== mEx ||
          {mem_valid, mem_memCtrl, mem_wbCtrl, mem_rd} !== {mMem.v, mMem.mc, mMem.wc, mMem.rd} ||
          {wb_valid, wb_wbCtrl, wb_rd} !== {mWb.v, mWb.wc, mWb.rd} ||
          retired_cnt !== CNT_W'(mCnt)) begin
        miss++;
        $display("FAIL rand_state[%0d]: ex=%h mem=%h wb=%h cnt=%0d want ex=%h mem=%h wb=%h cnt=%0d",
                 n, {ex_valid, ex_exCtrl, ex_memCtrl, ex_wbCtrl, ex_rd},
                 {mem_valid, mem_memCtrl, mem_wbCtrl, mem_rd}, {wb_valid, wb_wbCtrl, wb_rd},
                 retired_cnt, mEx, {mMem.v, mMem.mc, mMem.wc, mMem.rd},
                 {mWb.v, mWb.wc, mWb.rd}, mCnt);
      end
      // A stalled decode slot is re-presented; otherwise fetch a new one
      if (!st) begin
        drive(($urandom_range(0, 4) != 0), 3'($urandom), 3'($urandom), 2'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    brTaken = 1'b0;
    idle();
  endtask

  initial begin
    mEx = BUB; mMem = BUB; mWb = BUB; mCnt = 0;
    rst = 1'b1;
    brTaken = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_advance();
    test_load_use();
    test_load_rd0();
    test_branch_flush();
    test_stall_and_flush();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
